// File: rtl/flop_mult_pipe.sv
// flop_mult_pipe: three-stage pipelined small-float multiplier.
// The word layout is {sign, mant[MANT_W-1:0], exp[EXP_W-1:0]}.
// The value is (-1)^sign * mant/2^(MANT_W-1) * 2^exp, and exp is two's complement.
// Stage 1 multiplies. Stage 2 normalises on the leading one. Stage 3 range-checks and packs.
// All stages advance together on adv = !out_valid || out_ready.
module flop_mult_pipe #(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MANT_W+EXP_W:0]     one,
    input  logic [MANT_W+EXP_W:0]     other,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MANT_W+EXP_W:0]     result,
    output logic                      ovf,
    output logic                      unf
);

    localparam int W   = 1 + MANT_W + EXP_W;
    localparam int PW  = 2 * MANT_W;       // raw product width
    localparam int EW  = EXP_W + 2;        // internal exponent width, wide enough for lz adjust
    localparam int LZW = (PW > 1) ? $clog2(PW) : 1;

    // Representable exponent range of the output word, in internal width
    localparam logic [EW-1:0]    E_MAX     = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic [EW-1:0]    E_MIN     = EW'(-(2 ** (EXP_W - 1)));
    localparam logic [EXP_W-1:0] EXP_FIELD_MAX = EXP_W'(2 ** (EXP_W - 1) - 1);

    // Operand field extraction
    logic              sign_a, sign_b;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic [EXP_W-1:0]  exp_a, exp_b;

    assign sign_a = one[W-1];
    assign sign_b = other[W-1];
    assign mant_a = one[EXP_W +: MANT_W];
    assign mant_b = other[EXP_W +: MANT_W];
    assign exp_a  = one[EXP_W-1:0];
    assign exp_b  = other[EXP_W-1:0];

    // Single advance enable: a stalled output freezes the whole pipe
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ---------------- Stage 1: multiply ----------------
    logic              s1_valid_reg;
    logic              s1_sign_reg;
    logic              s1_zero_reg;
    logic [PW-1:0]     s1_prod_reg;
    logic [EW-1:0]     s1_exp_reg;

    logic [PW-1:0]     prod_next;
    logic [EW-1:0]     exp_sum_next;

    // Full-width product and sign-extended exponent sum
    always_comb begin
        prod_next    = PW'(mant_a) * PW'(mant_b);
        exp_sum_next = {{2{exp_a[EXP_W-1]}}, exp_a} + {{2{exp_b[EXP_W-1]}}, exp_b};
    end

    // Stage 1 register: capture the product and the exponent sum on advance
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_zero_reg  <= 1'b0;
            s1_prod_reg  <= '0;
            s1_exp_reg   <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_sign_reg  <= sign_a ^ sign_b;
            s1_zero_reg  <= (mant_a == '0) || (mant_b == '0);
            s1_prod_reg  <= prod_next;
            s1_exp_reg   <= exp_sum_next;
        end
    end

    // ---------------- Stage 2: normalise ----------------
    logic              s2_valid_reg;
    logic              s2_sign_reg;
    logic              s2_zero_reg;
    logic [MANT_W-1:0] s2_mant_reg;
    logic [EW-1:0]     s2_exp_reg;

    logic [LZW-1:0]    lz;
    logic [PW-1:0]     prod_shift;
    logic [MANT_W-1:0] mant_norm;
    logic [EW-1:0]     exp_norm;

    // Leading-zero count: scanning upward lets the highest set bit win.
    // A zero product leaves lz at 0, which is harmless because the zero flag overrides it.
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (s1_prod_reg[i]) begin
                lz = LZW'(PW - 1 - i);
            end
        end
        prod_shift = s1_prod_reg << lz;
        mant_norm  = MANT_W'(prod_shift >> MANT_W);
        // The binary point sits after bit PW-2 of the product, hence the +1
        exp_norm   = s1_exp_reg + EW'(1) - EW'(lz);
    end

    // Stage 2 register: normalised mantissa (truncated) and adjusted exponent
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_zero_reg  <= 1'b0;
            s2_mant_reg  <= '0;
            s2_exp_reg   <= '0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_zero_reg  <= s1_zero_reg;
            s2_mant_reg  <= mant_norm;
            s2_exp_reg   <= exp_norm;
        end
    end

    // ---------------- Stage 3: range check and pack ----------------
    logic             out_valid_reg;
    logic [W-1:0]     result_reg;
    logic             ovf_reg;
    logic             unf_reg;

    logic [W-1:0]     result_next;
    logic             ovf_next;
    logic             unf_next;

    // Zero outranks the range checks, so zero operands never raise a flag
    always_comb begin
        result_next = {s2_sign_reg, s2_mant_reg, s2_exp_reg[EXP_W-1:0]};
        ovf_next    = 1'b0;
        unf_next    = 1'b0;
        if (s2_zero_reg) begin
            result_next = '0;
        end else if ($signed(s2_exp_reg) > $signed(E_MAX)) begin
            result_next = {s2_sign_reg, {MANT_W{1'b1}}, EXP_FIELD_MAX};
            ovf_next    = 1'b1;
        end else if ($signed(s2_exp_reg) < $signed(E_MIN)) begin
            result_next = '0;
            unf_next    = 1'b1;
        end
    end

    // Output register: holds its value while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            ovf_reg       <= 1'b0;
            unf_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= s2_valid_reg;
            result_reg    <= result_next;
            ovf_reg       <= ovf_next;
            unf_reg       <= unf_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign ovf       = ovf_reg;
    assign unf       = unf_reg;

endmodule

// File: tb/tb_flop_mult_pipe.sv
// Directed testbench for flop_mult_pipe at default parameters (MANT_W=8, EXP_W=4).
// Table vectors are hand-computed products. Multi-cycle sequences cover streaming, backpressure and mid-stream reset.
module tb_flop_mult_pipe;

    localparam int W  = 13;
    localparam int NV = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] one;
    logic [W-1:0] other;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         ovf;
    logic         unf;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flop_mult_pipe #(.MANT_W(8), .EXP_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .one       (one),
        .other     (other),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        logic         unf;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input int k);
        check({tag, "_result"}, 32'(result), 32'(vecs[k].res));
        check({tag, "_ovf"}, 32'(ovf), 32'(vecs[k].ovf));
        check({tag, "_unf"}, 32'(unf), 32'(vecs[k].unf));
        $display("[TB] %s vec %0d: 0x%04h x 0x%04h -> 0x%04h ovf=%0b unf=%0b",
                 tag, k, vecs[k].a, vecs[k].b, result, ovf, unf);
    endtask

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int idx_in;
        int idx_out;
        int first_cyc;
        int last_cyc;
        int stall;
        int stall_total;
        int started;
        int ghosts;
        logic [W+1:0] held;

        //          a         b         result    ovf   unf
        vecs[0]  = '{13'h0800, 13'h0C00, 13'h0C00, 1'b0, 1'b0}; //  1.0 x 1.5
        vecs[1]  = '{13'h1C00, 13'h0C00, 13'h1901, 1'b0, 1'b0}; // -1.5 x 1.5 = -2.25
        vecs[2]  = '{13'h0C00, 13'h0C00, 13'h0901, 1'b0, 1'b0}; //  1.5 x 1.5
        vecs[3]  = '{13'h0C07, 13'h0C07, 13'h0FF7, 1'b1, 1'b0}; // e=15 overflow
        vecs[4]  = '{13'h0808, 13'h0808, 13'h0000, 1'b0, 1'b1}; // e=-16 underflow
        vecs[5]  = '{13'h0003, 13'h0C05, 13'h0000, 1'b0, 1'b0}; // zero mantissa
        vecs[6]  = '{13'h0010, 13'h0800, 13'h0809, 1'b0, 1'b0}; // unnormalised, lz=8
        vecs[7]  = '{13'h1C07, 13'h0C07, 13'h1FF7, 1'b1, 1'b0}; // negative overflow
        vecs[8]  = '{13'h1003, 13'h1800, 13'h0000, 1'b0, 1'b0}; // zero clears sign
        vecs[9]  = '{13'h0803, 13'h0804, 13'h0807, 1'b0, 1'b0}; // e=7, top of range
        vecs[10] = '{13'h0808, 13'h0800, 13'h0808, 1'b0, 1'b0}; // e=-8, bottom of range
        vecs[11] = '{13'h0808, 13'h0C0F, 13'h0000, 1'b0, 1'b1}; // e=-9 underflow
        vecs[12] = '{13'h0C04, 13'h0C03, 13'h0FF7, 1'b1, 1'b0}; // e=8 overflow
        vecs[13] = '{13'h0FF0, 13'h0FF0, 13'h0FE1, 1'b0, 1'b0}; // truncation 0xFE01 -> 0xFE
        vecs[14] = '{13'h1FF1, 13'h0010, 13'h1FFA, 1'b0, 1'b0}; // unnormalised, e=-6

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        one       = '0;
        other     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({ovf, unf}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single transactions: latency and value
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            one      = vecs[k].a;
            other    = vecs[k].b;
            in_valid = 1'b1;
            #1;
            check("idle_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);                 // accept edge
            #1 in_valid = 1'b0;
            @(negedge clk);
            cyc = 1;
            while (!out_valid && cyc < 8) begin
                @(negedge clk);
                cyc++;
            end
            // Cycle 0 presents the pair, so the result is visible in cycle 3
            check("latency", 32'(cyc), 32'd3);
            check_out("single", k);
        end

        // Full-rate streaming, out_ready held high
        @(negedge clk);
        idx_in = 0; idx_out = 0; first_cyc = -1; last_cyc = -1; cyc = 0;
        while (idx_out < NV && cyc < 100) begin
            if (out_valid) begin
                check_out("stream", idx_out);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                idx_out++;
            end
            if (idx_in < NV) begin
                one      = vecs[idx_in].a;
                other    = vecs[idx_in].b;
                in_valid = 1'b1;
                idx_in++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(idx_out), 32'(NV));
        check("stream_rate", 32'(last_cyc - first_cyc), 32'(NV - 1));

        // Backpressure: 5 pairs back to back, out_ready low for 4 cycles at first result
        idx_in = 0; idx_out = 0; stall = 0; stall_total = 0; started = 0; cyc = 0;
        held = '0;
        while (idx_out < 5 && cyc < 60) begin
            if (out_valid && started == 0) begin
                started = 1;
                stall   = 4;
                held    = {result, ovf, unf};
            end
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (idx_in < 5) begin
                one      = vecs[idx_in].a;
                other    = vecs[idx_in].b;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall > 0) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({result, ovf, unf}), 32'(held));
                $display("[TB] stall cycle: result=0x%04h in_ready=%0b", result, in_ready);
                stall--;
                stall_total++;
            end else if (out_valid) begin
                check_out("bp", idx_out);
                idx_out++;
            end
            if (in_valid && in_ready) idx_in++;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(idx_out), 32'd5);
        check("bp_stall_cycles", 32'(stall_total), 32'd4);

        // Reset with two operand pairs in flight
        one = vecs[0].a; other = vecs[0].b; in_valid = 1'b1;
        @(negedge clk);
        one = vecs[1].a; other = vecs[1].b;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", 32'({ovf, unf}), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        $display("[TB] mid-stream reset: out_valid=%0b result=0x%04h", out_valid, result);
        out_ready = 1'b1;
        ghosts = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("midrst_no_ghosts", 32'(ghosts), 32'd0);

        // A new pair after reset completes normally
        one = vecs[3].a; other = vecs[3].b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (!out_valid && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("postrst_latency", 32'(cyc), 32'd3);
        check_out("postrst", 3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
